// File: rtl/fp_div_arbiter_if.sv
// fp_div_arbiter_if: requester, divider and status signals of the shared
// FP divider arbiter.
//   slave  - arbiter view: request inputs, grant and result outputs, the
//            divider operands, the iDivResult input and oBusy.
//   master - environment view (requesters plus the divider), mirrored.
// oDivZero exists only when FP_DIV_ARB_DIVZERO_EN is defined.
interface fp_div_arbiter_if;
    logic        iEnable;
    logic        iReq0, iReq1;
    logic [31:0] iNum0, iDen0, iNum1, iDen1;
    logic        oGnt0, oGnt1;
    logic [31:0] oResult0, oResult1;
    logic        oResultValid0, oResultValid1;
    logic [31:0] oDivNum, oDivDen;
    logic        oDivValid;
    logic [31:0] iDivResult;
    logic        oBusy;
`ifdef FP_DIV_ARB_DIVZERO_EN
    logic        oDivZero;
`endif

    modport slave (
        input  iEnable, iReq0, iReq1, iNum0, iDen0, iNum1, iDen1, iDivResult,
        output oGnt0, oGnt1, oResult0, oResult1, oResultValid0, oResultValid1,
               oDivNum, oDivDen, oDivValid, oBusy
`ifdef FP_DIV_ARB_DIVZERO_EN
        , output oDivZero
`endif
    );

    modport master (
        output iEnable, iReq0, iReq1, iNum0, iDen0, iNum1, iDen1, iDivResult,
        input  oGnt0, oGnt1, oResult0, oResult1, oResultValid0, oResultValid1,
               oDivNum, oDivDen, oDivValid, oBusy
`ifdef FP_DIV_ARB_DIVZERO_EN
        , input oDivZero
`endif
    );
endinterface

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: shares one free-running, fixed-latency FP divider between
// two requesters. Round-robin registered grants, a DIV_LATENCY-deep tag
// pipeline that routes each quotient back to its requester in issue order.
//
// Ports:
//   iClock - sole clock, rising edge
//   iReset - asynchronous active-high reset
//   bus    - fp_div_arbiter_if.slave (requests, grants, results, divider
//            operands, divider result, oBusy)
// Parameter:
//   DIV_LATENCY - cycles from oDivValid to the matching iDivResult (>= 2)
// Optional feature macro:
//   FP_DIV_ARB_DIVZERO_EN - zero-exponent denominators yield a signed
//   infinity and pulse oDivZero with the result.
//
// state   | meaning
// S_IDLE  | nothing issuing, waiting for iEnable
// S_RUN   | grants allowed while iEnable is high
// S_DRAIN | iEnable low, waiting for in-flight tags to retire
module fp_div_arbiter #(
    parameter int DIV_LATENCY = 14
) (
    input  logic            iClock,
    input  logic            iReset,
    fp_div_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // High when requester 1 wins the next tie.
    logic prio1_q;

    logic [DIV_LATENCY-1:0] tag_valid_q;
    logic [DIV_LATENCY-1:0] tag_id_q;
`ifdef FP_DIV_ARB_DIVZERO_EN
    logic [DIV_LATENCY-1:0] tag_dz_q;
    logic [DIV_LATENCY-1:0] tag_sgn_q;
`endif

    logic        req0, req1;
    logic        gnt0_d, gnt1_d;
    logic        pipe_empty;
    logic [31:0] result_d;

    // A requester granted this cycle is still holding its request; mask it so
    // one grant issues exactly one operation.
    assign req0 = bus.iReq0 & ~bus.oGnt0;
    assign req1 = bus.iReq1 & ~bus.oGnt1;

    // oDivValid covers the cycle before a tag enters stage 0.
    assign pipe_empty = ~(|tag_valid_q) & ~bus.oDivValid;
    assign bus.oBusy  = (state_q != S_IDLE) | ~pipe_empty;

    always_comb begin
        state_d = state_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.iEnable) state_d = S_RUN;
            end
            S_RUN: begin
                if (!bus.iEnable) begin
                    state_d = S_DRAIN;
                end else begin
                    gnt0_d = req0 & (~req1 | ~prio1_q);
                    gnt1_d = req1 & (~req0 |  prio1_q);
                end
            end
            S_DRAIN: begin
                if (bus.iEnable)     state_d = S_RUN;
                else if (pipe_empty) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            bus.oGnt0     <= 1'b0;
            bus.oGnt1     <= 1'b0;
            bus.oDivValid <= 1'b0;
            bus.oDivNum   <= '0;
            bus.oDivDen   <= '0;
            prio1_q       <= 1'b0;
        end else begin
            bus.oGnt0     <= gnt0_d;
            bus.oGnt1     <= gnt1_d;
            bus.oDivValid <= gnt0_d | gnt1_d;
            if (gnt0_d) begin
                bus.oDivNum <= bus.iNum0;
                bus.oDivDen <= bus.iDen0;
                prio1_q     <= 1'b1;
            end else if (gnt1_d) begin
                bus.oDivNum <= bus.iNum1;
                bus.oDivDen <= bus.iDen1;
                prio1_q     <= 1'b0;
            end
        end
    end

    // Tags enter while the operation is on the divider inputs, so the last
    // stage lines up with iDivResult DIV_LATENCY cycles after oDivValid.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            tag_valid_q <= '0;
            tag_id_q    <= '0;
`ifdef FP_DIV_ARB_DIVZERO_EN
            tag_dz_q    <= '0;
            tag_sgn_q   <= '0;
`endif
        end else begin
            tag_valid_q <= {tag_valid_q[DIV_LATENCY-2:0], bus.oDivValid};
            tag_id_q    <= {tag_id_q[DIV_LATENCY-2:0], bus.oGnt1};
`ifdef FP_DIV_ARB_DIVZERO_EN
            tag_dz_q    <= {tag_dz_q[DIV_LATENCY-2:0], (bus.oDivDen[30:23] == 8'h00)};
            tag_sgn_q   <= {tag_sgn_q[DIV_LATENCY-2:0], bus.oDivNum[31] ^ bus.oDivDen[31]};
`endif
        end
    end

`ifdef FP_DIV_ARB_DIVZERO_EN
    assign result_d = tag_dz_q[DIV_LATENCY-1] ? {tag_sgn_q[DIV_LATENCY-1], 8'hFF, 23'h0}
                                              : bus.iDivResult;
`else
    assign result_d = bus.iDivResult;
`endif

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            bus.oResult0      <= '0;
            bus.oResult1      <= '0;
            bus.oResultValid0 <= 1'b0;
            bus.oResultValid1 <= 1'b0;
`ifdef FP_DIV_ARB_DIVZERO_EN
            bus.oDivZero      <= 1'b0;
`endif
        end else begin
            bus.oResultValid0 <= tag_valid_q[DIV_LATENCY-1] & ~tag_id_q[DIV_LATENCY-1];
            bus.oResultValid1 <= tag_valid_q[DIV_LATENCY-1] &  tag_id_q[DIV_LATENCY-1];
            if (tag_valid_q[DIV_LATENCY-1] && !tag_id_q[DIV_LATENCY-1]) bus.oResult0 <= result_d;
            if (tag_valid_q[DIV_LATENCY-1] &&  tag_id_q[DIV_LATENCY-1]) bus.oResult1 <= result_d;
`ifdef FP_DIV_ARB_DIVZERO_EN
            bus.oDivZero      <= tag_valid_q[DIV_LATENCY-1] & tag_dz_q[DIV_LATENCY-1];
`endif
        end
    end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: directed bench for fp_div_arbiter with a behavioural
// fixed-latency divider. Covers reset state, lone request latency, tie
// round-robin, drain on iEnable low, and reset with operations in flight;
// the divide-by-zero case runs when FP_DIV_ARB_DIVZERO_EN is defined.
module tb_fp_div_arbiter;
    localparam int L = 14;

    logic iClock = 1'b0;
    logic iReset = 1'b0;

    fp_div_arbiter_if bus();

    fp_div_arbiter #(.DIV_LATENCY(L)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 iClock = ~iClock;

    int n_err = 0;
    int n_chk = 0;

    // Stand-in quotient: 6.0/2.0 is exact, anything else gets a recognisable
    // operand mix so results can be told apart.
    function automatic logic [31:0] model_q(input logic [31:0] n, input logic [31:0] d);
        if (n == 32'h40C0_0000 && d == 32'h4000_0000) return 32'h4040_0000;
        return n ^ {d[15:0], d[31:16]};
    endfunction

    logic [31:0] dl [L];
    always @(posedge iClock) begin
        for (int i = L - 1; i > 0; i--) dl[i] <= dl[i-1];
        dl[0] <= bus.oDivValid ? model_q(bus.oDivNum, bus.oDivDen) : 32'h0;
    end
    assign bus.iDivResult = dl[L-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic check_all_zero(input string p);
        chk({p, "_ctl"}, 32'({bus.oGnt0, bus.oGnt1, bus.oResultValid0, bus.oResultValid1,
                              bus.oDivValid, bus.oBusy}), 32'h0);
        chk({p, "_res0"}, bus.oResult0, 32'h0);
        chk({p, "_res1"}, bus.oResult1, 32'h0);
        chk({p, "_dnum"}, bus.oDivNum, 32'h0);
        chk({p, "_dden"}, bus.oDivDen, 32'h0);
    endtask

    localparam logic [31:0] N0 = 32'h4120_0000, D0 = 32'h40A0_0000;
    localparam logic [31:0] N1 = 32'h42C8_0000, D1 = 32'h4120_0000;

    int cyc, idx, ngnt, nres, last, busy_low;
    logic got;

    initial begin
        bus.iEnable = 1'b0;
        bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
        bus.iNum0 = '0; bus.iDen0 = '0; bus.iNum1 = '0; bus.iDen1 = '0;

        // Reset state
        #2 iReset = 1'b1;
        #2 check_all_zero("rst");
        tick(); tick();
        iReset = 1'b0;
        tick();
        bus.iEnable = 1'b1;
        tick();
        chk("busy_run", 32'(bus.oBusy), 32'h1);

        // Lone request on requester 0
        bus.iNum0 = 32'h40C0_0000; bus.iDen0 = 32'h4000_0000; bus.iReq0 = 1'b1;
        tick();
        chk("lone_gnt", 32'({bus.oGnt1, bus.oGnt0, bus.oDivValid}), 32'h3);
        chk("lone_dnum", bus.oDivNum, 32'h40C0_0000);
        chk("lone_dden", bus.oDivDen, 32'h4000_0000);
        bus.iReq0 = 1'b0;
        cyc = 0; got = 1'b0;
        while (cyc < 40 && !got) begin
            tick(); cyc++;
            if (bus.oResultValid0) got = 1'b1;
        end
        chk("lone_lat", 32'(cyc), 32'd15);
        chk("lone_res", bus.oResult0, 32'h4040_0000);
        tick();
        chk("lone_rv_drop", 32'(bus.oResultValid0), 32'h0);
        chk("lone_hold", bus.oResult0, 32'h4040_0000);

        // Tie: re-home the pointer, then both requesters for 8 cycles
        iReset = 1'b1; tick(); iReset = 1'b0; tick();
        bus.iNum0 = N0; bus.iDen0 = D0; bus.iNum1 = N1; bus.iDen1 = D1;
        bus.iReq0 = 1'b1; bus.iReq1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("tie_gnt", 32'({bus.oGnt1, bus.oGnt0, bus.oDivValid}), (k % 2 == 1) ? 32'h3 : 32'h5);
        end
        bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
        idx = 0; cyc = 0;
        while (cyc < 40 && idx < 8) begin
            tick(); cyc++;
            if (bus.oResultValid0 || bus.oResultValid1) begin
                chk("tie_res_id", 32'({bus.oResultValid1, bus.oResultValid0}), (idx % 2 == 1) ? 32'h2 : 32'h1);
                chk("tie_res_val", (idx % 2 == 1) ? bus.oResult1 : bus.oResult0,
                    (idx % 2 == 1) ? model_q(N1, D1) : model_q(N0, D0));
                idx++;
            end
        end
        chk("tie_count", 32'(idx), 32'd8);

        // Drain: 5 grants, then iEnable low with requests still pending
        bus.iReq0 = 1'b1; bus.iReq1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("drain_gnt", 32'({bus.oGnt1, bus.oGnt0, bus.oDivValid}), (k % 2 == 1) ? 32'h3 : 32'h5);
        end
        bus.iEnable = 1'b0;
        cyc = 0; ngnt = 0; nres = 0; last = 0; busy_low = 0;
        while (cyc < 60 && busy_low == 0) begin
            tick(); cyc++;
            if (bus.oGnt0 || bus.oGnt1 || bus.oDivValid) ngnt++;
            if (bus.oResultValid0 || bus.oResultValid1) begin
                chk("drain_res_id", 32'({bus.oResultValid1, bus.oResultValid0}), (nres % 2 == 1) ? 32'h2 : 32'h1);
                nres++; last = cyc;
            end
            if (!bus.oBusy) busy_low = cyc;
        end
        chk("drain_nogrant", 32'(ngnt), 32'd0);
        chk("drain_nres", 32'(nres), 32'd5);
        chk("drain_last", 32'(last), 32'd15);
        chk("drain_busy_fall", 32'(busy_low), 32'd16);
        chk("drain_idle", 32'(dut.state_q), 32'd0);
        bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;

        // Reset with three operations in flight
        bus.iEnable = 1'b1;
        tick();
        bus.iReq0 = 1'b1; bus.iReq1 = 1'b1;
        repeat (3) tick();
        bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
        repeat (6) tick();
        #2 iReset = 1'b1;
        #1 check_all_zero("rst_mid");
        chk("rst_mid_state", 32'(dut.state_q), 32'd0);
        tick(); tick();
        iReset = 1'b0;
        nres = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.oResultValid0 || bus.oResultValid1) nres++;
        end
        chk("rst_mid_noresult", 32'(nres), 32'd0);

`ifdef FP_DIV_ARB_DIVZERO_EN
        // Divide by zero on requester 1
        bus.iNum1 = 32'hBF80_0000; bus.iDen1 = 32'h0000_0000; bus.iReq1 = 1'b1;
        tick();
        bus.iReq1 = 1'b0;
        cyc = 0; got = 1'b0;
        while (cyc < 40 && !got) begin
            tick(); cyc++;
            if (bus.oResultValid1) got = 1'b1;
        end
        chk("dz_lat", 32'(cyc), 32'd15);
        chk("dz_res", bus.oResult1, 32'hFF80_0000);
        chk("dz_flag", 32'(bus.oDivZero), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
